// File: rtl/adder_32bit_pkg.sv
// Shared constants and the slice-level carry lookahead for adder_32bit.
// Latency depends on ADDER32_PIPE_EN (2 when defined, 1 otherwise).
package adder_32bit_pkg;

   localparam int unsigned ADDER32_W   = 32;
   localparam int unsigned SLICE_W     = 4;
   localparam int unsigned NUM_SLICES  = 8;
   localparam int unsigned HALF_SLICES = NUM_SLICES / 2;
   localparam int unsigned HALF_W      = ADDER32_W / 2;

`ifdef ADDER32_PIPE_EN
   localparam int unsigned LATENCY = 2;
`else
   localparam int unsigned LATENCY = 1;
`endif

   // Carries into each of four slices plus the carry out, each written as a flat
   // sum of products over slice generate/propagate terms (no ripple between slices).
   function automatic logic [HALF_SLICES:0] group_carry(input logic [HALF_SLICES-1:0] g,
                                                        input logic [HALF_SLICES-1:0] p,
                                                        input logic               c0);
      logic [HALF_SLICES:0] c;
      logic                 term;
      c    = '0;
      c[0] = c0;
      for (int i = 1; i <= int'(HALF_SLICES); i++) begin
         for (int j = 0; j < i; j++) begin
            term = g[j];
            for (int k = j + 1; k < i; k++) term = term & p[k];
            c[i] = c[i] | term;
         end
         term = c0;
         for (int k = 0; k < i; k++) term = term & p[k];
         c[i] = c[i] | term;
      end
      return c;
   endfunction

endpackage

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead slice: sum bits plus slice-level generate/propagate.
module cla_4bit
   import adder_32bit_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] sum,
   output logic               g,
   output logic               p
);

   logic [SLICE_W-1:0] gb;
   logic [SLICE_W-1:0] pb;
   logic [SLICE_W-1:0] c;

   always_comb begin
      gb   = a & b;
      pb   = a ^ b;
      c[0] = cin;
      c[1] = gb[0] | (pb[0] & cin);
      c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & cin);
      c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
           | (pb[2] & pb[1] & pb[0] & cin);
      sum  = pb ^ c;
      g    = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
           | (pb[3] & pb[2] & pb[1] & gb[0]);
      p    = &pb;
   end

endmodule

// File: rtl/adder_32bit.sv
// Registered 32-bit carry-lookahead adder with carry-in/out.
// ADDER32_PIPE_EN splits the add at bit 16 into two register stages.
module adder_32bit
   import adder_32bit_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [ADDER32_W-1:0] a,
   input  logic [ADDER32_W-1:0] b,
   input  logic                 cin,
   input  logic                 in_valid,
   output logic [ADDER32_W-1:0] sum,
   output logic                 cout,
   output logic                 out_valid
);

   logic [ADDER32_W-1:0]  slice_a;
   logic [ADDER32_W-1:0]  slice_b;
   logic [ADDER32_W-1:0]  slice_sum;
   logic [NUM_SLICES-1:0] slice_g;
   logic [NUM_SLICES-1:0] slice_p;
   logic [NUM_SLICES-1:0] slice_cin;
   logic [HALF_SLICES:0]  lo_c;
   logic [HALF_SLICES:0]  hi_c;
   logic [HALF_W-1:0]     hi_a;
   logic [HALF_W-1:0]     hi_b;
   logic                  hi_cin;

   logic [ADDER32_W-1:0]  sum_q;
   logic [ADDER32_W-1:0]  sum_d;
   logic                  cout_q;
   logic                  cout_d;
   logic                  valid_q;
   logic                  valid_d;

   // Second-level lookahead: lower half from cin, upper half from the bit-16 carry
   always_comb begin
      slice_a   = {hi_a, a[HALF_W-1:0]};
      slice_b   = {hi_b, b[HALF_W-1:0]};
      lo_c      = group_carry(slice_g[HALF_SLICES-1:0], slice_p[HALF_SLICES-1:0], cin);
      hi_c      = group_carry(slice_g[NUM_SLICES-1:HALF_SLICES],
                              slice_p[NUM_SLICES-1:HALF_SLICES], hi_cin);
      slice_cin = {hi_c[HALF_SLICES-1:0], lo_c[HALF_SLICES-1:0]};
   end

   for (genvar i = 0; i < int'(NUM_SLICES); i++) begin : g_slice
      cla_4bit u_cla (
         .a   (slice_a[i*SLICE_W +: SLICE_W]),
         .b   (slice_b[i*SLICE_W +: SLICE_W]),
         .cin (slice_cin[i]),
         .sum (slice_sum[i*SLICE_W +: SLICE_W]),
         .g   (slice_g[i]),
         .p   (slice_p[i])
      );
   end

`ifdef ADDER32_PIPE_EN
   logic              s1_valid_q;
   logic [HALF_W-1:0] s1_a_hi_q;
   logic [HALF_W-1:0] s1_b_hi_q;
   logic              s1_c16_q;
   logic [HALF_W-1:0] s1_sum_lo_q;

   // Stage 1: low half result and the operands/carry the upper half needs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_a_hi_q   <= '0;
         s1_b_hi_q   <= '0;
         s1_c16_q    <= 1'b0;
         s1_sum_lo_q <= '0;
      end else begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_a_hi_q   <= a[ADDER32_W-1:HALF_W];
            s1_b_hi_q   <= b[ADDER32_W-1:HALF_W];
            s1_c16_q    <= lo_c[HALF_SLICES];
            s1_sum_lo_q <= slice_sum[HALF_W-1:0];
         end
      end
   end

   always_comb begin
      hi_a    = s1_a_hi_q;
      hi_b    = s1_b_hi_q;
      hi_cin  = s1_c16_q;
      valid_d = s1_valid_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      if (s1_valid_q) begin
         sum_d  = {slice_sum[ADDER32_W-1:HALF_W], s1_sum_lo_q};
         cout_d = hi_c[HALF_SLICES];
      end
   end
`else
   always_comb begin
      hi_a    = a[ADDER32_W-1:HALF_W];
      hi_b    = b[ADDER32_W-1:HALF_W];
      hi_cin  = lo_c[HALF_SLICES];
      valid_d = in_valid;
      sum_d   = sum_q;
      cout_d  = cout_q;
      if (in_valid) begin
         sum_d  = slice_sum;
         cout_d = hi_c[HALF_SLICES];
      end
   end
`endif

   // Output registers hold the last accepted result while idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q   <= '0;
         cout_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         valid_q <= valid_d;
      end
   end

   assign sum       = sum_q;
   assign cout      = cout_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_adder_32bit.sv
// Scoreboard bench for adder_32bit; expectations follow LATENCY from the package.
`timescale 1ns/1ps
module tb_adder_32bit;
   import adder_32bit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;
   logic        in_valid;
   logic [31:0] sum;
   logic        cout;
   logic        out_valid;

   typedef struct packed {
      logic        v;
      logic        c;
      logic [31:0] s;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] held_s;
   logic        held_c;
   int          checks = 0;
   int          errors = 0;

   adder_32bit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .in_valid  (in_valid),
      .sum       (sum),
      .cout      (cout),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one input set, clock once, then compare against the scoreboard head
   task automatic step(input logic v, input logic [31:0] x, input logic [31:0] y,
                       input logic ci, input string tag);
      exp_t e;
      a        = x;
      b        = y;
      cin      = ci;
      in_valid = v;
      e.v      = v;
      {e.c, e.s} = {1'b0, x} + {1'b0, y} + 33'(ci);
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() >= int'(LATENCY)) begin
         e = sb.pop_front();
         if (e.v) begin
            held_s = e.s;
            held_c = e.c;
         end
         check({tag, "_valid"}, 33'(out_valid), 33'(e.v));
      end else begin
         check({tag, "_valid"}, 33'(out_valid), 33'b0);
      end
      check({tag, "_result"}, {cout, sum}, {held_c, held_s});
   endtask

   task automatic assert_reset(input string tag);
      rst_n = 1'b0;
      #1;
      check({tag, "_async"}, {out_valid, cout, sum}, 34'b0);
      sb.delete();
      held_s = '0;
      held_c = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      a        = 32'd5;
      b        = 32'd9;
      cin      = 1'b0;
      in_valid = 1'b1;
      held_s   = '0;
      held_c   = 1'b0;
      #1;
      check("reset_t0", {out_valid, cout, sum}, 34'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("reset_hold", {out_valid, cout, sum}, 34'b0);
      end
      rst_n = 1'b1;

      step(1'b1, 32'd0,   32'd0,  1'b0, "add_0_0");
      step(1'b1, 32'd5,   32'd9,  1'b0, "add_5_9");
      step(1'b1, 32'd16,  32'd32, 1'b0, "add_16_32");
      step(1'b1, 32'd128, 32'd64, 1'b0, "add_128_64");
      step(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "carry_wrap");
      step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "carry_all1");
      step(1'b1, 32'h0000_FFFF, 32'h0000_0000, 1'b1, "cin_bit16");
      step(1'b1, 32'h0FFF_FFFF, 32'h0000_0001, 1'b0, "slice_ripple");
      for (int i = 0; i < 3; i++) step(1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, "idle_hold");
      step(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, "msb_carry");
      step(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1, "in_flight");

      #2;
      assert_reset("midrst");
      @(posedge clk);
      #1;
      check("midrst_hold", {out_valid, cout, sum}, 34'b0);
      rst_n = 1'b1;
      step(1'b0, 32'd1, 32'd1, 1'b0, "post_rst_idle");
      step(1'b0, 32'd1, 32'd1, 1'b0, "post_rst_idle2");
      step(1'b1, 32'd7, 32'd8, 1'b1, "post_rst_first");
      step(1'b1, 32'd1, 32'd2, 1'b0, "post_rst_second");

      for (int i = 0; i < 10000; i++) begin
         step(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 1)),
              "rand");
      end
      for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 32'd0, 1'b0, "drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
